// File: rtl/sr_dmem_mmio.sv
// sr_dmem_mmio -- data-side responder for the core's general memory port.
//
// Serves core loads/stores from a word-addressed data RAM and a small I/O
// window holding a GPIO output register, a synchronised GPIO input and a
// 32-bit compare timer with a sticky match flag.
//
// Ports:
//   clk             clock
//   rst_n           asynchronous active-low reset (RAM contents are kept)
//   memAddr[31:0]   byte address from the core, bits [1:0] ignored
//   memWriteEnable  store strobe; the core owns memData while high
//   memData[31:0]   inout: store data in (we=1) / load data out (we=0)
//   gpioIn          asynchronous external inputs
//   gpioOut         GPIO output register
//   timerIrq        timer sticky match flag
//
// Register map (byte offset from MMIO_BASE):
//   0x00 GPIO_OUT RW   0x04 GPIO_IN RO   0x08 TMR_CNT RW
//   0x0C TMR_CMP  RW   0x10 TMR_CTRL {MATCH (W1C), EN}
module sr_dmem_mmio #(
    parameter int          RAM_WORDS = 64,
    parameter logic [31:0] MMIO_BASE = 32'h0001_0000,
    parameter int          GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       memAddr,
    input  logic              memWriteEnable,
    inout  wire  [31:0]       memData,
    input  logic [GPIO_W-1:0] gpioIn,
    output logic [GPIO_W-1:0] gpioOut,
    output logic              timerIrq
);

    localparam int          IDX_W     = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

    localparam logic [5:0] OFS_GPIO_OUT = 6'h00;
    localparam logic [5:0] OFS_GPIO_IN  = 6'h01;
    localparam logic [5:0] OFS_TMR_CNT  = 6'h02;
    localparam logic [5:0] OFS_TMR_CMP  = 6'h03;
    localparam logic [5:0] OFS_TMR_CTRL = 6'h04;

    logic [31:0]       ram [RAM_WORDS];
    logic [GPIO_W-1:0] gpioOutReg;
    logic [GPIO_W-1:0] syncMeta;
    logic [GPIO_W-1:0] syncOut;
    logic [31:0]       cnt;
    logic [31:0]       cmp;
    logic              en;
    logic              match;

    // ---------------------------------------------------------------
    // Decode. RAM wins if a (degenerate) MMIO_BASE of 0 would overlap.
    // ---------------------------------------------------------------
    logic             isRam;
    logic             isMmio;
    logic [IDX_W-1:0] ramIdx;
    logic [5:0]       mmioOfs;
    logic [31:0]      wrData;

    assign isRam   = memAddr < RAM_BYTES;
    assign isMmio  = !isRam && (memAddr[31:16] == MMIO_BASE[31:16]);
    assign ramIdx  = memAddr[IDX_W+1:2];
    assign mmioOfs = memAddr[7:2];
    assign wrData  = memData;

    logic ramWr, gpioWr, cntWr, cmpWr, ctrlWr;

    assign ramWr  = memWriteEnable && isRam;
    assign gpioWr = memWriteEnable && isMmio && (mmioOfs == OFS_GPIO_OUT);
    assign cntWr  = memWriteEnable && isMmio && (mmioOfs == OFS_TMR_CNT);
    assign cmpWr  = memWriteEnable && isMmio && (mmioOfs == OFS_TMR_CMP);
    assign ctrlWr = memWriteEnable && isMmio && (mmioOfs == OFS_TMR_CTRL);

    // ---------------------------------------------------------------
    // Load path: purely combinational, released whenever the core writes.
    // ---------------------------------------------------------------
    logic [31:0] mmioRd;
    logic [31:0] rdData;

    always_comb begin
        mmioRd = 32'h0;
        unique case (mmioOfs)
            OFS_GPIO_OUT: mmioRd = 32'(gpioOutReg);
            OFS_GPIO_IN:  mmioRd = 32'(syncOut);
            OFS_TMR_CNT:  mmioRd = cnt;
            OFS_TMR_CMP:  mmioRd = cmp;
            OFS_TMR_CTRL: mmioRd = {30'h0, match, en};
            default:      mmioRd = 32'h0;
        endcase
    end

    always_comb begin
        rdData = 32'h0;
        if (isRam)
            rdData = ram[ramIdx];
        else if (isMmio)
            rdData = mmioRd;
    end

    assign memData = memWriteEnable ? 32'hz : rdData;

    // ---------------------------------------------------------------
    // Data RAM: no reset so contents survive a core reset.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (ramWr)
            ram[ramIdx] <= wrData;
    end

    // ---------------------------------------------------------------
    // GPIO output register and input synchroniser.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpioOutReg <= '0;
            syncMeta   <= '0;
            syncOut    <= '0;
        end else begin
            syncMeta <= gpioIn;
            syncOut  <= syncMeta;
            if (gpioWr)
                gpioOutReg <= wrData[GPIO_W-1:0];
        end
    end

    assign gpioOut = gpioOutReg;

    // ---------------------------------------------------------------
    // Timer. Match is judged on pre-edge cnt/cmp/EN; a match event beats
    // a simultaneous W1C of MATCH so an edge is never lost.
    // ---------------------------------------------------------------
    logic matchEv;
    logic matchClr;

    assign matchEv  = en && (cnt == cmp);
    assign matchClr = ctrlWr && wrData[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            cmp   <= '0;
            en    <= 1'b0;
            match <= 1'b0;
        end else begin
            if (cntWr)
                cnt <= wrData;
            else if (en)
                cnt <= cnt + 32'd1;
            if (cmpWr)
                cmp <= wrData;
            if (ctrlWr)
                en <= wrData[0];
            match <= matchEv || (match && !matchClr);
        end
    end

    assign timerIrq = match;

endmodule
